// File: rtl/refresh_scroller_if.sv
// Handshake and scroll-report bundle between the game-state FSM (master)
// and the refresh scroller (slave).
interface refresh_scroller_if;
  logic [2:0]  outstate;
  logic [9:0]  doodle_y;
  logic        refresh_en;
  logic        trigger;
  logic        scroll_valid;
  logic [5:0]  scroll_dy;
  logic [15:0] scroll_total;

  modport master (
    output outstate, doodle_y,
    input  refresh_en, trigger, scroll_valid, scroll_dy, scroll_total
  );

  modport slave (
    input  outstate, doodle_y,
    output refresh_en, trigger, scroll_valid, scroll_dy, scroll_total
  );
endinterface

// File: rtl/refresh_scroller.sv
// Refresh scroller: requests a world scroll when the doodle climbs above the
// scroll line, then scrolls one step per frame until the doodle sits at
// TARGET_Y, acknowledging completion to the game-state FSM.
module refresh_scroller #(
  parameter logic [9:0] SCROLL_LINE = 10'd160,
  parameter logic [9:0] TARGET_Y    = 10'd400,
  parameter logic [5:0] SCROLL_STEP = 6'd4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                frame_clk,
  refresh_scroller_if.slave   bus
);

  localparam logic [2:0] OS_LOADING = 3'b001;
  localparam logic [2:0] OS_GAME    = 3'b010;
  localparam logic [2:0] OS_REFRESH = 3'b100;

  typedef enum logic [1:0] {IDLE, REQUEST, SCROLL, DONE} state_t;

  state_t      state;
  logic [9:0]  remaining;
  logic        frame_meta;
  logic        frame_sync;
  logic        frame_prev;
  logic        frame_tick;
  logic [5:0]  step;
  logic [16:0] total_sum;
  logic [15:0] total_sat;

  // Bring frame_clk into the Clock domain and turn its rising edge into a
  // registered one-cycle tick.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
      frame_prev <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
      frame_tick <= frame_sync & ~frame_prev;
    end
  end

  // Step size for this frame (last step may be partial) and the saturated
  // running total it would produce.
  always_comb begin
    step = SCROLL_STEP;
    if (remaining < {4'd0, SCROLL_STEP}) begin
      step = remaining[5:0];
    end
    total_sum = {1'b0, bus.scroll_total} + {11'd0, step};
    total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];
  end

  // Handshake FSM with registered outputs; the new-game clear of
  // scroll_total is written last so it overrides any accumulate.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= IDLE;
      remaining        <= 10'd0;
      bus.refresh_en   <= 1'b0;
      bus.trigger      <= 1'b0;
      bus.scroll_valid <= 1'b0;
      bus.scroll_dy    <= 6'd0;
      bus.scroll_total <= 16'd0;
    end else begin
      bus.scroll_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.refresh_en <= 1'b0;
          bus.trigger    <= 1'b0;
          if (bus.outstate == OS_GAME && bus.doodle_y < SCROLL_LINE) begin
            remaining      <= TARGET_Y - bus.doodle_y;
            state          <= REQUEST;
            bus.refresh_en <= 1'b1;
          end
        end
        REQUEST: begin
          if (bus.outstate == OS_REFRESH) begin
            state          <= SCROLL;
            bus.refresh_en <= 1'b0;
          end else if (bus.outstate != OS_GAME) begin
            state          <= IDLE;
            remaining      <= 10'd0;
            bus.refresh_en <= 1'b0;
          end
        end
        SCROLL: begin
          bus.refresh_en <= 1'b0;
          if (bus.outstate != OS_REFRESH) begin
            // FSM left Refreshing early: abort without acknowledging.
            state     <= IDLE;
            remaining <= 10'd0;
          end else if (remaining == 10'd0) begin
            state       <= DONE;
            bus.trigger <= 1'b1;
          end else if (frame_tick) begin
            bus.scroll_valid <= 1'b1;
            bus.scroll_dy    <= step;
            bus.scroll_total <= total_sat;
            remaining        <= remaining - {4'd0, step};
            if (remaining == {4'd0, step}) begin
              state       <= DONE;
              bus.trigger <= 1'b1;
            end
          end
        end
        DONE: begin
          remaining <= 10'd0;
          if (bus.outstate != OS_REFRESH) begin
            state       <= IDLE;
            bus.trigger <= 1'b0;
          end else begin
            bus.trigger <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= 10'd0;
        end
      endcase
      if (bus.outstate == OS_LOADING) begin
        bus.scroll_total <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_refresh_scroller.sv
// Directed bench for refresh_scroller: default instance for the handshake,
// scrolling and reset cases, plus a large-step instance for saturation.
module tb_refresh_scroller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_clk = 1'b0;

  int errors = 0;
  int checks = 0;
  int pulses1 = 0;
  int sum1 = 0;
  int p_snap;
  int s_snap;

  refresh_scroller_if b1 ();
  refresh_scroller_if b2 ();

  refresh_scroller dut1 (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .frame_clk(frame_clk),
    .bus      (b1.slave)
  );

  refresh_scroller #(
    .SCROLL_LINE(10'd160),
    .TARGET_Y   (10'd1023),
    .SCROLL_STEP(6'd63)
  ) dut2 (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .frame_clk(frame_clk),
    .bus      (b2.slave)
  );

  always #5 clk = ~clk;

  // Tally scroll pulses of the default instance.
  always @(negedge clk) begin
    if (b1.scroll_valid === 1'b1) begin
      pulses1 = pulses1 + 1;
      sum1 = sum1 + int'(b1.scroll_dy);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One frame strobe: 4 Clocks high, 4 low; the scroll pulse lands inside.
  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic refresh2();
    b2.doodle_y = 10'd0;
    b2.outstate = 3'b010;
    @(negedge clk);
    b2.outstate = 3'b100;
    @(negedge clk);
    repeat (17) frame_pulse();
    b2.outstate = 3'b010;
    b2.doodle_y = 10'd500;
    @(negedge clk);
  endtask

  initial begin
    b1.outstate = 3'b000;
    b1.doodle_y = 10'd300;
    b2.outstate = 3'b000;
    b2.doodle_y = 10'd500;
    repeat (3) @(negedge clk);
    check("reset_refresh_en", {31'd0, b1.refresh_en}, 32'd0);
    check("reset_outputs", {23'd0, b1.trigger, b1.scroll_valid, b1.scroll_dy}, 32'd0);
    check("reset_total", {16'd0, b1.scroll_total}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full scroll from doodle_y=100: 75 steps of 4.
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd100;
    @(negedge clk);
    check("full_refresh_en", {31'd0, b1.refresh_en}, 32'd1);
    b1.outstate = 3'b100;
    b1.doodle_y = 10'd50;
    @(negedge clk);
    check("full_refresh_en_drop", {31'd0, b1.refresh_en}, 32'd0);
    p_snap = pulses1;
    s_snap = sum1;
    repeat (74) frame_pulse();
    check("full_no_trigger_74", {31'd0, b1.trigger}, 32'd0);
    frame_pulse();
    check("full_trigger", {31'd0, b1.trigger}, 32'd1);
    check("full_pulses", pulses1 - p_snap, 32'd75);
    check("full_sum", sum1 - s_snap, 32'd300);
    check("full_dy", {26'd0, b1.scroll_dy}, 32'd4);
    check("full_total", {16'd0, b1.scroll_total}, 32'd300);
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd300;
    @(negedge clk);
    check("full_trigger_clear", {31'd0, b1.trigger}, 32'd0);

    // Partial last step: 242 = 60*4 + 2.
    b1.doodle_y = 10'd158;
    @(negedge clk);
    check("part_refresh_en", {31'd0, b1.refresh_en}, 32'd1);
    b1.outstate = 3'b100;
    @(negedge clk);
    p_snap = pulses1;
    s_snap = sum1;
    repeat (60) frame_pulse();
    check("part_no_trigger_60", {31'd0, b1.trigger}, 32'd0);
    frame_pulse();
    check("part_last_dy", {26'd0, b1.scroll_dy}, 32'd2);
    check("part_trigger", {31'd0, b1.trigger}, 32'd1);
    check("part_pulses", pulses1 - p_snap, 32'd61);
    check("part_sum", sum1 - s_snap, 32'd242);
    check("part_total", {16'd0, b1.scroll_total}, 32'd542);
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd300;
    @(negedge clk);

    // Threshold: 160 never requests, 159 does with remaining 241.
    b1.doodle_y = 10'd160;
    repeat (100) @(negedge clk);
    check("thr_160_no_request", {31'd0, b1.refresh_en}, 32'd0);
    b1.doodle_y = 10'd159;
    @(negedge clk);
    check("thr_159_request", {31'd0, b1.refresh_en}, 32'd1);
    b1.outstate = 3'b100;
    @(negedge clk);
    s_snap = sum1;
    repeat (61) frame_pulse();
    check("thr_last_dy", {26'd0, b1.scroll_dy}, 32'd1);
    check("thr_trigger", {31'd0, b1.trigger}, 32'd1);
    check("thr_sum", sum1 - s_snap, 32'd241);
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd300;
    @(negedge clk);

    // Cancel from REQUEST via Pause.
    b1.doodle_y = 10'd100;
    @(negedge clk);
    check("cancel_request", {31'd0, b1.refresh_en}, 32'd1);
    b1.outstate = 3'b011;
    @(negedge clk);
    check("cancel_drop", {31'd0, b1.refresh_en}, 32'd0);
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd300;
    repeat (5) @(negedge clk);
    check("cancel_no_rerequest", {31'd0, b1.refresh_en}, 32'd0);

    // Asynchronous reset in the middle of a scroll.
    b1.doodle_y = 10'd100;
    @(negedge clk);
    b1.outstate = 3'b100;
    @(negedge clk);
    repeat (10) frame_pulse();
    check("rst_pre_total", {16'd0, b1.scroll_total}, 32'd823);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {8'd0, b1.refresh_en, b1.trigger, b1.scroll_valid, b1.scroll_dy, b1.scroll_total[14:0]},
          32'd0);
    check("rst_async_total", {16'd0, b1.scroll_total}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p_snap = pulses1;
    repeat (3) frame_pulse();
    check("rst_no_scroll", pulses1 - p_snap, 32'd0);
    check("rst_no_trigger", {31'd0, b1.trigger}, 32'd0);

    // New-game clear at the cycle a step would be taken.
    b1.outstate = 3'b010;
    b1.doodle_y = 10'd100;
    @(negedge clk);
    b1.outstate = 3'b100;
    @(negedge clk);
    repeat (2) frame_pulse();
    check("clr_pre_total", {16'd0, b1.scroll_total}, 32'd8);
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    b1.outstate = 3'b001;
    b1.doodle_y = 10'd300;
    @(negedge clk);
    check("clr_total", {16'd0, b1.scroll_total}, 32'd0);
    b1.outstate = 3'b010;
    repeat (4) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    p_snap = pulses1;
    frame_pulse();
    check("clr_aborted", pulses1 - p_snap, 32'd0);

    // Saturation on the large-step instance: 1023 per refresh.
    for (int r = 0; r < 64; r++) begin
      refresh2();
      if (r == 0) begin
        check("sat_last_dy", {26'd0, b2.scroll_dy}, 32'd15);
        check("sat_first_total", {16'd0, b2.scroll_total}, 32'd1023);
      end
    end
    check("sat_pre_total", {16'd0, b2.scroll_total}, 32'd65472);
    refresh2();
    check("sat_pinned", {16'd0, b2.scroll_total}, 32'd65535);
    refresh2();
    check("sat_stays", {16'd0, b2.scroll_total}, 32'd65535);
    b2.outstate = 3'b001;
    @(negedge clk);
    check("sat_clear", {16'd0, b2.scroll_total}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
